// File: rtl/imgproc_cmd_ctrl.sv
// Command front-end of the image processor: range-checks {cmd, cmd_data}, launches a frame
// on the read stage and tracks it to completion or timeout.
module imgproc_cmd_ctrl #(
  parameter int unsigned MAX_ANGLE      = 90,
  parameter int unsigned MAX_ZOOM       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cmd,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ack,
  output logic       busy,
  output logic       refresh,
  output logic       error,
  output logic [1:0] mode,
  output logic [7:0] param,
  output logic       start,
  input  logic       frame_done
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN
  } state_t;

  state_t        state_q;
  logic          armed_q;
  logic [CW-1:0] cnt_q;
  logic          cmd_ack_q;
  logic          busy_q;
  logic          refresh_q;
  logic          error_q;
  logic [1:0]    mode_q;
  logic [7:0]    param_q;
  logic          start_q;

  logic legal;
  logic accept;

  always_comb begin
    legal = 1'b0;
    case (cmd)
      4'd0:       legal = ({24'd0, cmd_data} <= MAX_ANGLE);
      4'd1:       legal = (cmd_data != 8'd0) && ({24'd0, cmd_data} <= MAX_ZOOM);
      4'd2, 4'd3: legal = 1'b1;
      default:    legal = 1'b0;
    endcase
  end

  assign accept = (state_q == S_IDLE) && cmd_valid && armed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      armed_q   <= 1'b1;
      cnt_q     <= '0;
      cmd_ack_q <= 1'b0;
      busy_q    <= 1'b0;
      refresh_q <= 1'b0;
      error_q   <= 1'b0;
      mode_q    <= '0;
      param_q   <= '0;
      start_q   <= 1'b0;
    end else begin
      cmd_ack_q <= 1'b0;
      refresh_q <= 1'b0;
      start_q   <= 1'b0;

      // A request must be seen low once before another one is taken.
      if (!cmd_valid) begin
        armed_q <= 1'b1;
      end else if (accept) begin
        armed_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cmd_ack_q <= 1'b1;
            if (legal) begin
              mode_q  <= cmd[1:0];
              param_q <= cmd[1] ? '0 : cmd_data;
              error_q <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= S_START;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        S_START: begin
          start_q <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (frame_done) begin
            busy_q    <= 1'b0;
            refresh_q <= 1'b1;
            state_q   <= S_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            busy_q  <= 1'b0;
            error_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ack = cmd_ack_q;
  assign busy    = busy_q;
  assign refresh = refresh_q;
  assign error   = error_q;
  assign mode    = mode_q;
  assign param   = param_q;
  assign start   = start_q;

endmodule

// File: tb/tb_imgproc_cmd_ctrl.sv
// Scoreboard bench for imgproc_cmd_ctrl: stimulus pushes expected acks/frame ends, a negedge
// monitor pops and compares; a second short-timeout instance covers the timeout path.
module tb_imgproc_cmd_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, cmd_valid, frame_done;
  logic [3:0] cmd;
  logic [7:0] cmd_data;
  logic       cmd_ack, busy, refresh, error, start;
  logic [1:0] mode;
  logic [7:0] param;

  logic       t_rst, t_valid, t_fd;
  logic       t_ack, t_busy, t_refresh, t_error, t_start;
  logic [1:0] t_mode;
  logic [7:0] t_param;

  imgproc_cmd_ctrl #(.MAX_ANGLE(90), .MAX_ZOOM(8), .TIMEOUT_CYCLES(500000)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ack(cmd_ack), .busy(busy), .refresh(refresh), .error(error), .mode(mode),
    .param(param), .start(start), .frame_done(frame_done)
  );

  imgproc_cmd_ctrl #(.MAX_ANGLE(90), .MAX_ZOOM(8), .TIMEOUT_CYCLES(16)) dut16 (
    .clk(clk), .rst(t_rst), .cmd(4'd3), .cmd_data(8'd0), .cmd_valid(t_valid),
    .cmd_ack(t_ack), .busy(t_busy), .refresh(t_refresh), .error(t_error), .mode(t_mode),
    .param(t_param), .start(t_start), .frame_done(t_fd)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    bit         is_end;
    logic       err;
    logic       busy;
    logic       refresh;
    logic [1:0] mode;
    logic [7:0] param;
  } exp_t;

  exp_t q[$];

  // Reference model state: what mode/param/error should read after each event.
  logic [1:0] m_mode;
  logic [7:0] m_param;
  logic       m_err;

  function automatic bit model_legal(input int c, input int d);
    if (c > 3) return 1'b0;
    if (c == 0) return d <= 90;
    if (c == 1) return (d >= 1) && (d <= 8);
    return 1'b1;
  endfunction

  // Monitor
  logic       mon_en = 1'b0;
  logic       p_ack, p_busy;
  logic [1:0] p_mode;
  logic [7:0] p_param;
  exp_t       me;

  always @(negedge clk) begin
    if (mon_en) begin
      if (cmd_ack) begin
        check("ack_expected", (q.size() > 0 && !q[0].is_end), 1'b1);
        if (q.size() > 0 && !q[0].is_end) begin
          me = q.pop_front();
          check("ack_error", error, me.err);
          check("ack_busy", busy, me.busy);
          check("ack_mode", mode, me.mode);
          check("ack_param", param, me.param);
        end
      end
      if (p_busy && !busy) begin
        check("end_expected", (q.size() > 0 && q[0].is_end), 1'b1);
        if (q.size() > 0 && q[0].is_end) begin
          me = q.pop_front();
          check("end_refresh", refresh, me.refresh);
          check("end_error", error, me.err);
        end
      end else if (refresh) begin
        check("spurious_refresh", refresh, 1'b0);
      end
      if (start || (p_ack && p_busy))
        check("start_after_ack", start, p_ack && p_busy);
      if (busy && p_busy) begin
        check("mode_stable", mode, p_mode);
        check("param_stable", param, p_param);
      end
      p_ack   = cmd_ack;
      p_busy  = busy;
      p_mode  = mode;
      p_param = param;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One idle edge with cmd_valid low re-arms, then one edge with the request presented.
  task automatic issue(input int c, input int d, input bit hold, output bit lg);
    exp_t e;
    lg = model_legal(c, d);
    if (lg) begin
      m_mode  = 2'(c);
      m_param = (c >= 2) ? 8'd0 : 8'(d);
      m_err   = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    e = '{is_end: 1'b0, err: m_err, busy: lg, refresh: 1'b0, mode: m_mode, param: m_param};
    q.push_back(e);
    tick();
    cmd      = 4'(c);
    cmd_data = 8'(d);
    cmd_valid = 1'b1;
    tick();
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Called just after accept edge E; frame_done is sampled at edge E+k.
  task automatic run_frame(input int k, input bit noise);
    exp_t e;
    e = '{is_end: 1'b1, err: 1'b0, busy: 1'b0, refresh: 1'b1, mode: m_mode, param: m_param};
    q.push_back(e);
    for (int i = 1; i < k; i++) begin
      if (noise && k >= 8 && i == 3) begin
        cmd       = 4'($urandom_range(0, 15));
        cmd_valid = 1'b1;
      end
      if (noise && k >= 8 && i == 5) cmd_valid = 1'b0;
      tick();
    end
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  function automatic int pick_data();
    case ($urandom_range(0, 7))
      0: return 0;
      1: return 1;
      2: return 8;
      3: return 9;
      4: return 90;
      5: return 91;
      6: return 255;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    bit   lg;
    exp_t e;
    int   n;
    bit   saw_ref;

    // Reset with a request pending: nothing may be acknowledged.
    rst = 1'b1; t_rst = 1'b1;
    cmd = 4'd0; cmd_data = 8'd10; cmd_valid = 1'b1; frame_done = 1'b0;
    t_valid = 1'b0; t_fd = 1'b0;
    tick();
    check("rst_ack_c1", cmd_ack, 1'b0);
    tick();
    check("rst_ack", cmd_ack, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_refresh", refresh, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_start", start, 1'b0);
    check("rst_mode", mode, 2'd0);
    check("rst_param", param, 8'd0);
    rst = 1'b0; t_rst = 1'b0; cmd_valid = 1'b0;
    m_mode = '0; m_param = '0; m_err = 1'b0;
    p_ack = 1'b0; p_busy = 1'b0; p_mode = '0; p_param = '0;
    mon_en = 1'b1;

    issue(0, 10, 1'b0, lg);
    run_frame(50, 1'b0);

    issue(0, 91, 1'b0, lg);
    issue(2, 8'h55, 1'b0, lg);
    run_frame(5, 1'b0);

    issue(5, 0, 1'b0, lg);
    issue(1, 0, 1'b0, lg);
    issue(1, 8, 1'b0, lg);
    run_frame(2, 1'b0);
    issue(1, 9, 1'b0, lg);

    // Request held high across the whole frame and beyond: one ack only.
    issue(1, 3, 1'b1, lg);
    run_frame(12, 1'b0);
    repeat (5) tick();
    cmd_valid = 1'b0;

    // Reset mid-frame: busy falls with no refresh and everything returns to reset values.
    issue(0, 45, 1'b0, lg);
    repeat (10) tick();
    e = '{is_end: 1'b1, err: 1'b0, busy: 1'b0, refresh: 1'b0, mode: 2'd0, param: 8'd0};
    q.push_back(e);
    rst = 1'b1;
    m_mode = '0; m_param = '0; m_err = 1'b0;
    tick();
    rst = 1'b0;
    check("midrst_mode", mode, 2'd0);
    check("midrst_param", param, 8'd0);
    issue(1, 2, 1'b0, lg);
    run_frame(20, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int c, d;
      c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
      d = pick_data();
      issue(c, d, 1'b0, lg);
      if (lg) run_frame(int'($urandom_range(2, 40)), 1'($urandom_range(0, 1)));
      else if ($urandom_range(0, 1) == 1) begin
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
      end
    end
    repeat (3) tick();
    check("scoreboard_drained", q.size(), 0);

    // Timeout path on the 16-cycle instance.
    tick();
    t_valid = 1'b1;
    tick();
    t_valid = 1'b0;
    check("to_ack", t_ack, 1'b1);
    check("to_busy", t_busy, 1'b1);
    tick();
    check("to_start", t_start, 1'b1);
    n = 0; saw_ref = 1'b0;
    while (t_busy && n < 40) begin
      tick();
      n++;
      saw_ref |= t_refresh;
    end
    check("to_len", n, 16);
    check("to_error", t_error, 1'b1);
    check("to_no_refresh", saw_ref, 1'b0);
    check("to_mode", t_mode, 2'd3);

    // frame_done on the terminal-count edge wins over the timeout.
    tick();
    t_valid = 1'b1;
    tick();
    t_valid = 1'b0;
    check("tc_ack", t_ack, 1'b1);
    tick();
    check("tc_start", t_start, 1'b1);
    repeat (15) tick();
    check("tc_busy_before", t_busy, 1'b1);
    t_fd = 1'b1;
    tick();
    t_fd = 1'b0;
    check("tc_busy", t_busy, 1'b0);
    check("tc_refresh", t_refresh, 1'b1);
    check("tc_error", t_error, 1'b0);
    tick();
    check("tc_refresh_pulse", t_refresh, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
